// File: rtl/colour_round_ctrl.sv
// Round controller behind the colour picker: picks a target, judges presses, tracks score/lives.
// Optional COLOUR_ROUND_SPEEDUP_EN: round limit shrinks by STEP_TICKS per hit down to MIN_TICKS.
module colour_round_ctrl #(
  parameter int ROUND_TICKS = 50000000,
  parameter int LIVES       = 3,
  parameter int SCORE_W     = 8,
  parameter int MIN_TICKS   = 12500000,
  parameter int STEP_TICKS  = 2500000
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               press,
  input  logic [2:0]         target_col,
  input  logic [2:0]         wheel_col,
  output logic               pick_en,
  output logic [2:0]         target_q,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         lives,
  output logic               hit,
  output logic               miss,
  output logic               game_over
);

  localparam int TW = $clog2(ROUND_TICKS + 1);

  if (ROUND_TICKS < 2 || LIVES < 1 || LIVES > 15 || MIN_TICKS < 1 ||
      MIN_TICKS > ROUND_TICKS || STEP_TICKS < 0) begin : g_bad_param
    $error("colour_round_ctrl: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PICK   = 3'd1,
    S_PLAY   = 3'd2,
    S_RESULT = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic          start_d, press_d;
  logic          start_edge, press_edge;
  logic          res_hit;
  logic          timeout, judge_hit, judge_miss;
  logic [TW-1:0] timer;
  logic [TW-1:0] limit;

  assign start_edge = start & ~start_d;
  assign press_edge = press & ~press_d;

`ifdef COLOUR_ROUND_SPEEDUP_EN
  localparam logic [TW-1:0] MIN_L  = TW'(MIN_TICKS);
  localparam logic [TW-1:0] STEP_L = TW'(STEP_TICKS);

  // limit never drops below MIN_L, so the difference cannot underflow
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      limit <= TW'(ROUND_TICKS);
    end else if ((state == S_IDLE || state == S_OVER) && start_edge) begin
      limit <= TW'(ROUND_TICKS);
    end else if (state == S_PLAY && judge_hit) begin
      limit <= ((limit - MIN_L) >= STEP_L) ? (limit - STEP_L) : MIN_L;
    end
  end
`else
  assign limit = TW'(ROUND_TICKS);
`endif

  // a press in the final cycle wins over the timeout
  assign timeout    = (timer == limit - TW'(1));
  assign judge_hit  = press_edge && (wheel_col == target_q);
  assign judge_miss = (press_edge && (wheel_col != target_q)) || (!press_edge && timeout);

  always_comb begin
    state_nxt = state;
    pick_en   = 1'b0;
    hit       = 1'b0;
    miss      = 1'b0;
    game_over = 1'b0;
    case (state)
      S_IDLE: if (start_edge) state_nxt = S_PICK;
      S_PICK: begin
        pick_en   = 1'b1;
        state_nxt = S_PLAY;
      end
      S_PLAY: if (judge_hit || judge_miss) state_nxt = S_RESULT;
      S_RESULT: begin
        hit       = res_hit;
        miss      = ~res_hit;
        state_nxt = (lives == 4'd0) ? S_OVER : S_PICK;
      end
      S_OVER: begin
        game_over = 1'b1;
        if (start_edge) state_nxt = S_PICK;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      start_d  <= 1'b0;
      press_d  <= 1'b0;
      target_q <= 3'b001;
      score    <= '0;
      lives    <= 4'd0;
      timer    <= '0;
      res_hit  <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_d <= start;
      press_d <= press;
      case (state)
        S_IDLE, S_OVER: begin
          if (start_edge) begin
            score <= '0;
            lives <= 4'(LIVES);
          end
        end
        S_PICK: begin
          target_q <= target_col;
          timer    <= '0;
        end
        S_PLAY: begin
          timer <= timer + TW'(1);
          if (judge_hit) begin
            res_hit <= 1'b1;
            if (score != {SCORE_W{1'b1}}) score <= score + SCORE_W'(1);
          end else if (judge_miss) begin
            res_hit <= 1'b0;
            if (lives != 4'd0) lives <= lives - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_colour_round_ctrl.sv
// Scoreboard bench for colour_round_ctrl: stimulus queues expected outcomes, a monitor checks pulses.
module tb_colour_round_ctrl;

  logic       clock = 1'b0;
  logic       resetn, start, press;
  logic [2:0] target_col, wheel_col;
  logic       pick_en, hit, miss, game_over;
  logic [2:0] target_q;
  logic [7:0] score;
  logic [3:0] lives;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    bit h;
    int score;
    int lives;
    int cyc;
  } exp_t;
  exp_t sbq[$];

  int         m_score, m_lives, m_limit, play_cyc;
  logic [2:0] m_tq;

  colour_round_ctrl #(
    .ROUND_TICKS(16), .LIVES(3), .SCORE_W(8), .MIN_TICKS(8), .STEP_TICKS(4)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start), .press(press),
    .target_col(target_col), .wheel_col(wheel_col), .pick_en(pick_en),
    .target_q(target_q), .score(score), .lives(lives), .hit(hit),
    .miss(miss), .game_over(game_over)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // monitor: every hit/miss pulse must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (hit || miss) begin
        if (sbq.size() == 0) begin
          chk("unexpected_pulse", {30'd0, hit, miss}, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("hit_miss_excl", hit & miss, 0);
          chk("outcome_hit", hit, e.h);
          chk("outcome_miss", miss, !e.h);
          chk("result_score", score, e.score);
          chk("result_lives", lives, e.lives);
          chk("result_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic start_game(input logic [2:0] tc);
    target_col = tc;
    start = 1'b1;
    tick;
    chk("pick_en_on", pick_en, 1);
    chk("lives_load", lives, 3);
    chk("score_clr", score, 0);
    tick;
    start = 1'b0;
    chk("pick_en_one_cycle", pick_en, 0);
    chk("target_latch", target_q, tc);
    chk("game_over_low", game_over, 0);
    m_score = 0; m_lives = 3; m_limit = 16; m_tq = tc; play_cyc = cyc;
  endtask

  // called at the first PLAY cycle; n = timer value at which press rises
  task automatic play_round(input int n, input bit do_press, input logic [2:0] wheel,
                            input logic [2:0] next_tc, input bit hold);
    bit h;
    int rc;
    int nn;
    wheel_col  = wheel;
    target_col = next_tc;
    if (do_press) begin
      nn = (n >= m_limit) ? m_limit - 1 : n;
      repeat (nn) tick;
      press = 1'b1;
      h  = (wheel == m_tq);
      rc = cyc + 1;
    end else begin
      h  = 1'b0;
      rc = play_cyc + m_limit;
      repeat (m_limit - 1) tick;
    end
    if (h) begin
      if (m_score < 255) m_score++;
`ifdef COLOUR_ROUND_SPEEDUP_EN
      m_limit = (m_limit - 8 >= 4) ? m_limit - 4 : 8;
`endif
    end else begin
      m_lives--;
    end
    sbq.push_back('{h, m_score, m_lives, rc});
    tick;
    if (!hold) press = 1'b0;
    tick;
    if (m_lives == 0) begin
      chk("game_over_set", game_over, 1);
      chk("no_pick_in_over", pick_en, 0);
    end else begin
      chk("pick_after_result", pick_en, 1);
      tick;
      chk("next_target", target_q, next_tc);
      m_tq = next_tc;
      play_cyc = cyc;
    end
  endtask

  initial begin
    resetn = 1'b1; start = 1'b0; press = 1'b0;
    target_col = 3'b000; wheel_col = 3'b000;
    #1 resetn = 1'b0;
    #2;
    chk("rst_pick_en", pick_en, 0);
    chk("rst_target_q", target_q, 3'b001);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 0);
    chk("rst_hit_miss", {hit, miss}, 0);
    chk("rst_game_over", game_over, 0);
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    tick;

    start_game(3'b100);
    play_round(2, 1, 3'b100, 3'b110, 0);   // hit
    play_round(5, 1, 3'b110, 3'b010, 0);   // hit at PLAY cycle 5
    play_round(3, 1, 3'b001, 3'b100, 1);   // miss, press held
    play_round(0, 0, 3'b001, 3'b100, 1);   // held press gives only the timeout
    press = 1'b0;
    play_round(15, 1, 3'b100, 3'b001, 0);  // press coincident with timeout: hit
    play_round(0, 0, 3'b010, 3'b001, 0);   // last life lost

    press = 1'b1; tick; tick; press = 1'b0; tick;
    chk("over_hold_go", game_over, 1);
    chk("over_hold_score", score, m_score);
    chk("over_hold_lives", lives, 0);

    start_game(3'b010);
    repeat (3) play_round(0, 0, 3'b100, 3'b010, 0);
    chk("three_timeouts_lives", lives, 0);

    start_game(3'b001);
    repeat (4) tick;
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_score", score, 0);
    chk("async_rst_lives", lives, 0);
    chk("async_rst_target", target_q, 3'b001);
    chk("async_rst_outs", {pick_en, hit, miss, game_over}, 0);
    @(posedge clock);
    #1 resetn = 1'b1;
    tick;

    start_game(3'b100);
    repeat (256) play_round(0, 1, 3'b100, 3'b100, 0);
    chk("score_saturated", score, 255);

    repeat (4) tick;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
